input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning input-stable cycles required to accept a button change (10 ms at 50 MHz); legal range 2 to 2^24-1.
REQ-002 SHALL have parameter SW_WIDTH, default 10, meaning width of the slide-switch bus.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port button_n  input  1  raw push button, asynchronous, active-low (0 = pressed).
REQ-006 SHALL have port switches_raw  input  SW_WIDTH  raw slide switches, asynchronous.
REQ-007 SHALL have port clear_event  input  1  processor acknowledge; clears event_flag.
REQ-008 SHALL have port switches  output  SW_WIDTH  synchronized switches, fed to the data-memory peripheral map.
REQ-009 SHALL have port button  output  1  debounced level, active-high (1 = pressed).
REQ-010 SHALL have port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-011 SHALL have port release_pulse  output  1  one-cycle strobe on accepted release.
REQ-012 SHALL have port event_flag  output  1  sticky "press occurred" flag.
REQ-013 SHALL have port press_count  output  8  count of accepted presses, wrapping.

Function
REQ-014 SHALL pass switches_raw through a 2-flop synchronizer; switches equals switches_raw sampled 2 edges earlier; no debounce on switches.
REQ-015 SHALL pass ~button_n through a 2-flop synchronizer producing internal btn_s (1 = pressed).
REQ-016 SHALL implement FSM states RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE, plus a 24-bit stability counter cnt.
REQ-017 RELEASED: btn_s=1 -> WAIT_PRESS with cnt=0; otherwise hold.
REQ-018 WAIT_PRESS: btn_s=0 -> RELEASED, cnt=0 (bounce rejected, no pulse); btn_s=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1; btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED.
REQ-019 PRESSED/WAIT_RELEASE SHALL mirror REQ-017/018 with btn_s polarity inverted, returning to RELEASED on acceptance.
REQ-020 button SHALL be a registered output: 1 in PRESSED and WAIT_RELEASE, 0 in RELEASED and WAIT_PRESS.
REQ-021 press_pulse SHALL be registered, high for exactly the one cycle following the WAIT_PRESS->PRESSED edge; release_pulse likewise for WAIT_RELEASE->RELEASED.
REQ-022 For a clean, held input change, the strobe SHALL become visible after rising edge DEBOUNCE_CYCLES+3, counting the edge that first samples the new button_n level as edge 1.
REQ-023 press_pulse and release_pulse SHALL never be high in the same cycle.
REQ-024 event_flag SHALL set on press_pulse and clear on clear_event; simultaneous set and clear SHALL leave it set (set wins).
REQ-025 press_count SHALL increment by 1 on each press_pulse and wrap 255->0 with no saturation or flag.
REQ-026 clear_event SHALL affect only event_flag, never press_count or the FSM.

Reset
REQ-027 On reset=1 at a rising edge, the block SHALL enter RELEASED with cnt=0 and both synchronizer stages holding "released".
REQ-028 The same edge SHALL set button, press_pulse, release_pulse, event_flag, press_count to 0 and switches/synchronizer to 0.
REQ-029 Reset SHALL dominate all inputs, including clear_event and a pending acceptance.
REQ-030 Reset asserted mid-debounce (WAIT_*) SHALL abort without emitting a strobe.
REQ-031 After reset deasserts with button_n held low, a full press SHALL be accepted per REQ-022.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, button_n=1, switches_raw=0x3FF -> outputs all 0 at reset; switches=0x3FF two edges after release; all other outputs stay 0.
REQ-033 button_n driven 0 and held -> press_pulse=1 only after edge 7; button=1 from edge 7; event_flag=1; press_count=1.
REQ-034 button_n low 2 cycles then high (bounce) -> no press_pulse; button=0; press_count=0.
REQ-035 After a press, button_n=1 held -> release_pulse=1 after edge 7; button=0; event_flag remains 1; press_count unchanged.
REQ-036 clear_event=1 in the press_pulse cycle -> event_flag=1; clear_event=1 next cycle -> event_flag=0.
REQ-037 256 clean presses -> press_count wraps to 0x00; then reset asserted in WAIT_PRESS with cnt=2 -> no strobe; state RELEASED; press_count=0.

Source files
------------

// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions the board's raw user inputs for the processor: a 2-flop
//   synchronizer on the slide switches, and a synchronized, debounced push
//   button with press/release strobes, a sticky press flag and a wrapping
//   press counter.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous, active-high
//   button_n       in   raw push button, asynchronous, 0 = pressed
//   switches_raw   in   raw slide switches, asynchronous
//   clear_event    in   processor acknowledge, clears event_flag
//   switches       out  synchronized switches
//   button         out  debounced level, 1 = pressed
//   press_pulse    out  one-cycle strobe on accepted press
//   release_pulse  out  one-cycle strobe on accepted release
//   event_flag     out  sticky "press occurred" flag
//   press_count    out  accepted presses, wraps 255 -> 0
//
// Debounce FSM
//   state        | meaning
//   RELEASED     | stable released, watching for btn_s = 1
//   WAIT_PRESS   | btn_s = 1, counting stable cycles toward acceptance
//   PRESSED      | stable pressed, watching for btn_s = 0
//   WAIT_RELEASE | btn_s = 0, counting stable cycles toward acceptance

module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SW_WIDTH        = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                button_n,
    input  logic [SW_WIDTH-1:0] switches_raw,
    input  logic                clear_event,
    output logic [SW_WIDTH-1:0] switches,
    output logic                button,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                event_flag,
    output logic [7:0]          press_count
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sw_meta_q;
    logic [SW_WIDTH-1:0] sw_sync_q;
    logic                btn_meta_q;
    logic                btn_sync_q;

    state_t              state_q;
    logic [23:0]         cnt_q;
    logic                button_q;
    logic                press_pulse_q;
    logic                release_pulse_q;
    logic                event_flag_q;
    logic                event_flag_d;
    logic [7:0]          press_count_q;
    logic [7:0]          press_count_d;

    // Synchronizers; the button is inverted on entry so "pressed" is 1
    // everywhere inside the block and the reset value means "released".
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= switches_raw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= ~button_n;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce FSM with registered level and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RELEASED;
            cnt_q           <= '0;
            button_q        <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (btn_sync_q) begin
                        state_q <= WAIT_PRESS;
                        cnt_q   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!btn_sync_q) begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q       <= PRESSED;
                        cnt_q         <= '0;
                        button_q      <= 1'b1;
                        press_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                PRESSED: begin
                    if (!btn_sync_q) begin
                        state_q <= WAIT_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    if (btn_sync_q) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q         <= RELEASED;
                        cnt_q           <= '0;
                        button_q        <= 1'b0;
                        release_pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Flag and counter react to the registered strobe, so a clear_event
    // arriving in the strobe cycle collides with the set and loses.
    always_comb begin
        event_flag_d  = event_flag_q;
        press_count_d = press_count_q;
        if (press_pulse_q) begin
            event_flag_d  = 1'b1;
            press_count_d = press_count_q + 8'd1;
        end else if (clear_event) begin
            event_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_flag_q  <= 1'b0;
            press_count_q <= 8'd0;
        end else begin
            event_flag_q  <= event_flag_d;
            press_count_q <= press_count_d;
        end
    end

    assign switches      = sw_sync_q;
    assign button        = button_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign event_flag    = event_flag_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button_n = 1'b1;
    logic [SW-1:0] switches_raw = '0;
    logic          clear_event = 1'b0;
    logic [SW-1:0] switches;
    logic          button;
    logic          press_pulse;
    logic          release_pulse;
    logic          event_flag;
    logic [7:0]    press_count;

    int n_assert = 0;
    int n_fail   = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW)) dut (
        .clk           (clk),
        .reset         (reset),
        .button_n      (button_n),
        .switches_raw  (switches_raw),
        .clear_event   (clear_event),
        .switches      (switches),
        .button        (button),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .event_flag    (event_flag),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: a synchronized copy of the button is compared with the
    // accepted level; a change is accepted once it has been seen on D+1
    // consecutive edges. Flag and counter follow the strobe one edge later.
    logic          m_s1 = 0, m_s2 = 0;
    logic [SW-1:0] m_sw1 = '0, m_sw2 = '0;
    logic          m_lvl = 0, m_pp = 0, m_rp = 0, m_ev = 0;
    logic [7:0]    m_pc = '0;
    int            m_run = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_sw1 = '0; m_sw2 = '0;
            m_lvl = 0; m_pp = 0; m_rp = 0; m_ev = 0; m_pc = '0; m_run = 0;
        end else begin
            if (m_pp) m_ev = 1'b1;
            else if (clear_event) m_ev = 1'b0;
            m_pc = m_pc + (m_pp ? 8'd1 : 8'd0);
            m_pp = 0;
            m_rp = 0;
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    if (m_lvl) m_pp = 1; else m_rp = 1;
                end
            end else begin
                m_run = 0;
            end
            m_s2  = m_s1;
            m_s1  = ~button_n;
            m_sw2 = m_sw1;
            m_sw1 = switches_raw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("switches",      32'(switches),      32'(m_sw2));
        chk("button",        32'(button),        32'(m_lvl));
        chk("press_pulse",   32'(press_pulse),   32'(m_pp));
        chk("release_pulse", 32'(release_pulse), 32'(m_rp));
        chk("event_flag",    32'(event_flag),    32'(m_ev));
        chk("press_count",   32'(press_count),   32'(m_pc));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int hold;

        // Reset with switches high: everything reads 0.
        reset = 1; button_n = 1; switches_raw = 10'h3FF;
        step(); step();
        chk("rst_switches", 32'(switches), 32'h0);
        chk("rst_count", 32'(press_count), 32'h0);
        reset = 0;
        step();
        chk("sw_edge1", 32'(switches), 32'h0);
        step();
        chk("sw_edge2", 32'(switches), 32'h3FF);
        step(); step();

        // Clean press: strobe appears only after edge D+3.
        button_n = 0;
        for (int i = 1; i < D + 3; i++) begin
            step();
            chk("press_early", 32'(press_pulse), 32'h0);
        end
        step();
        chk("press_edge7", 32'(press_pulse), 32'h1);
        chk("button_edge7", 32'(button), 32'h1);
        clear_event = 1;                       // collides with the set
        step();
        chk("ev_set_wins", 32'(event_flag), 32'h1);
        chk("count_one", 32'(press_count), 32'h1);
        step();
        chk("ev_cleared", 32'(event_flag), 32'h0);
        clear_event = 0;
        step();

        // Clean release.
        button_n = 1;
        for (int i = 1; i < D + 3; i++) begin
            step();
            chk("release_early", 32'(release_pulse), 32'h0);
        end
        step();
        chk("release_edge7", 32'(release_pulse), 32'h1);
        chk("button_rel", 32'(button), 32'h0);
        chk("count_kept", 32'(press_count), 32'h1);
        step(); step();

        // Bounce: two low cycles are rejected.
        button_n = 0;
        step(); step();
        button_n = 1;
        for (int i = 0; i < 10; i++) step();
        chk("bounce_btn", 32'(button), 32'h0);
        chk("bounce_count", 32'(press_count), 32'h1);

        // Random runs of button levels, switches and acknowledges.
        for (int k = 0; k < 60; k++) begin
            button_n = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 9));
            for (int h = 0; h < hold; h++) begin
                switches_raw = SW'($urandom);
                clear_event  = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        clear_event = 0;
        button_n = 1;
        for (int i = 0; i < 10; i++) step();

        // 256 clean presses from reset wrap the counter.
        reset = 1;
        step();
        reset = 0;
        step();
        for (int p = 0; p < 256; p++) begin
            button_n = 0;
            for (int i = 0; i < 9; i++) step();
            button_n = 1;
            for (int i = 0; i < 9; i++) step();
            if (p == 254) chk("count_255", 32'(press_count), 32'hFF);
        end
        chk("count_wrap", 32'(press_count), 32'h0);

        // Reset in WAIT_PRESS (cnt = 2 after edge 5) aborts without a strobe.
        button_n = 0;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        step();
        chk("abort_pp", 32'(press_pulse), 32'h0);
        chk("abort_btn", 32'(button), 32'h0);
        step();
        chk("abort_pp2", 32'(press_pulse), 32'h0);
        chk("abort_count", 32'(press_count), 32'h0);

        // Button still held low as reset drops: full press timing again.
        reset = 0;
        for (int i = 1; i < D + 3; i++) begin
            step();
            chk("post_rst_early", 32'(press_pulse), 32'h0);
        end
        step();
        chk("post_rst_press", 32'(press_pulse), 32'h1);
        step();
        chk("post_rst_count", 32'(press_count), 32'h1);
        button_n = 1;
        for (int i = 0; i < 10; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
